sisc_fetch_unit: RTL and testbench
==================================

// Module: sisc_fetch_unit
// PURPOSE
//   Owns the SISC program counter and instruction register. Consumes the ctrl FSM strobes
//   (pc_rst, pc_write, pc_sel, br_sel, ir_load), fetches instructions from instruction memory
//   over a req/ack handshake of variable latency, and feeds the decoded fields
//   (opcode, mm, imm) back to ctrl. Sits between ctrl and the instruction memory.
// PARAMETERS
//   ADDR_W       16  PC / imem address width; also the width of the imm field
//   DATA_W       32  instruction width; opcode=ir[31:28], mm=ir[27:24], imm=ir[ADDR_W-1:0]
//   IMEM_TIMEOUT 15  maximum cycles imem_req may stay high without imem_ack (>=1)
// PORTS
//   clk          in   1       clock, rising edge
//   rst_f        in   1       reset, asynchronous, active-low
//   pc_rst       in   1       synchronous PC clear (from ctrl)
//   pc_write     in   1       PC update enable
//   pc_sel       in   1       0: PC+1, 1: branch target
//   br_sel       in   1       0: absolute target = imm, 1: relative target = PC+imm
//   ir_load      in   1       start an instruction fetch at the current PC
//   imem_req     out  1       fetch request, registered
//   imem_addr    out  ADDR_W  fetch address, stable while imem_req=1
//   imem_ack     in   1       memory has data on imem_data this cycle
//   imem_data    in   DATA_W  instruction word
//   pc           out  ADDR_W  current program counter
//   ir           out  DATA_W  instruction register
//   opcode       out  4       ir[31:28]
//   mm           out  4       ir[27:24]
//   imm          out  ADDR_W  ir[ADDR_W-1:0]
//   fetch_stall  out  1       1 while a fetch is outstanding; ctrl holds its state
//   fetch_fault  out  1       sticky: imem timeout occurred
// BEHAVIOUR
//   Reset (rst_f=0, async): pc=0, ir=0 (NOOP), imem_req=0, imem_addr=0, fetch_stall=0,
//     fetch_fault=0, timeout counter=0, FSM=IDLE. Reset mid-transaction aborts it.
//   PC update, each rising edge, priority order:
//     pc_rst=1                  -> pc<=0 (overrides pc_write)
//     pc_write=1, pc_sel=0      -> pc<=pc+1
//     pc_write=1, pc_sel=1, br_sel=0 -> pc<=imm
//     pc_write=1, pc_sel=1, br_sel=1 -> pc<=pc+imm (imm two's complement)
//     otherwise pc holds. All arithmetic mod 2^ADDR_W (0xFFFF+1 -> 0).
//   The PC update is independent of the fetch FSM; a PC change while BUSY does not alter
//     the in-flight imem_addr.
//   FSM states: IDLE, BUSY, FAULT.
//     IDLE: ir_load=1 -> imem_addr<=pc (pre-update value, even if pc_write is also set this
//       edge), imem_req<=1, cnt<=0, BUSY. Otherwise stay.
//     BUSY: imem_req=1, fetch_stall=1 (combinational from state). On an edge with imem_ack=1:
//       ir<=imem_data, imem_req<=0, IDLE. Otherwise cnt<=cnt+1; if cnt==IMEM_TIMEOUT-1:
//       imem_req<=0, ir<=32'hF000_0000 (HLT), fetch_fault<=1, FAULT.
//       ir_load while BUSY is ignored. pc_rst does not abort the transaction.
//     FAULT: terminal until rst_f; imem_req=0, fetch_stall=0, ir holds HLT, ir_load ignored.
//   Handshake: imem_req rises only from IDLE and is held until the ack edge or timeout.
//     imem_ack while imem_req=0 is ignored. Ack can arrive as early as the first edge after
//     imem_req rises, giving a 1-cycle stall minimum.
//   Latency: ir_load at edge N -> imem_req=1 after N; ack sampled at edge N+k -> ir valid and
//     fetch_stall=0 after edge N+k.
//   opcode, mm and imm are pure slices of ir. ir changes only on an ack or timeout edge.
// TESTING
//   1 Reset: hold rst_f=0 mid-BUSY -> imem_req=0, pc=0, ir=0, stall=0, fault=0 immediately.
//   2 Sequential fetch: pc=4, ir_load+pc_write(sel=0), ack 2 cycles later with 0x8800_0005
//     -> imem_addr=4, pc=5, stall high for 2 cycles, opcode=8, mm=8, imm=5.
//   3 Branches: ir imm=0x0010, pc=0x20: absolute -> pc=0x0010; relative -> pc=0x0030;
//     imm=0xFFFE, pc=0x0001 relative -> pc=0xFFFF; pc=0xFFFF, +1 -> pc=0x0000.
//   4 Timeout: ir_load, never ack -> after 15 edges imem_req=0, fault=1, opcode=15, stall=0;
//     later ir_load ignored.
//   5 Priority: pc_rst=1 with pc_write=1, pc_sel=1 -> pc=0; ir_load during BUSY -> no new
//     request, imem_addr unchanged.
//   6 Stray ack: imem_ack=1 in IDLE with data 0xDEAD_BEEF -> ir unchanged.

Source files
------------

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: program counter, instruction register and the instruction-memory
// req/ack fetch engine with a bounded wait that parks in a sticky FAULT state.
module sisc_fetch_unit #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 32,
   parameter int IMEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_f,
   input  logic              pc_rst,
   input  logic              pc_write,
   input  logic              pc_sel,
   input  logic              br_sel,
   input  logic              ir_load,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_data,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [3:0]        opcode,
   output logic [3:0]        mm,
   output logic [ADDR_W-1:0] imm,
   output logic              fetch_stall,
   output logic              fetch_fault
);

   localparam int                CNT_W    = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
   localparam logic [DATA_W-1:0] HLT_WORD = {4'hF, {(DATA_W-4){1'b0}}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [ADDR_W-1:0]  pc_next_s;

   assign opcode = ir[DATA_W-1:DATA_W-4];
   assign mm     = ir[DATA_W-5:DATA_W-8];
   assign imm    = ir[ADDR_W-1:0];

   // Next PC: clear beats update; relative branches add imm as a two's complement offset
   always_comb begin
      pc_next_s = pc;
      if (pc_rst) begin
         pc_next_s = '0;
      end else if (pc_write) begin
         if (!pc_sel) begin
            pc_next_s = pc + PC_ONE;
         end else if (!br_sel) begin
            pc_next_s = imm;
         end else begin
            pc_next_s = pc + imm;
         end
      end else begin
         pc_next_s = pc;
      end
   end

   // Program counter register, independent of the fetch engine
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         pc <= '0;
      end else begin
         pc <= pc_next_s;
      end
   end

   // Fetch FSM; imem_addr latches the pre-update PC so a concurrent PC change cannot move it
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         imem_req    <= 1'b0;
         imem_addr   <= '0;
         ir          <= '0;
         fetch_stall <= 1'b0;
         fetch_fault <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (ir_load) begin
                  imem_addr   <= pc;
                  imem_req    <= 1'b1;
                  fetch_stall <= 1'b1;
                  cnt_r       <= '0;
                  state_r     <= BUSY;
               end
            end
            BUSY: begin
               if (imem_ack) begin
                  ir          <= imem_data;
                  imem_req    <= 1'b0;
                  fetch_stall <= 1'b0;
                  state_r     <= IDLE;
               end else if (cnt_r == CNT_LAST) begin
                  ir          <= HLT_WORD;
                  imem_req    <= 1'b0;
                  fetch_stall <= 1'b0;
                  fetch_fault <= 1'b1;
                  state_r     <= FAULT;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            FAULT: begin
               imem_req    <= 1'b0;
               fetch_stall <= 1'b0;
               fetch_fault <= 1'b1;
            end
            default: begin
               // Unreachable encoding: park safely with the core halted
               ir          <= HLT_WORD;
               imem_req    <= 1'b0;
               fetch_stall <= 1'b0;
               fetch_fault <= 1'b1;
               state_r     <= FAULT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit: fetch handshake, PC arithmetic, timeout and reset.
module tb_sisc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_f;
   logic        pc_rst, pc_write, pc_sel, br_sel, ir_load;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [15:0] pc;
   logic [31:0] ir;
   logic [3:0]  opcode, mm;
   logic [15:0] imm;
   logic        fetch_stall, fetch_fault;

   int n_cmp = 0;
   int n_bad = 0;

   sisc_fetch_unit #(.ADDR_W(16), .DATA_W(32), .IMEM_TIMEOUT(15)) dut (
      .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel),
      .br_sel(br_sel), .ir_load(ir_load), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .pc(pc), .ir(ir), .opcode(opcode),
      .mm(mm), .imm(imm), .fetch_stall(fetch_stall), .fetch_fault(fetch_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pc_rst = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
      ir_load = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
   endtask

   // pc_write with the given selects for one edge
   task automatic pc_op(input logic sel, input logic br);
      pc_write = 1'b1; pc_sel = sel; br_sel = br;
      step();
      pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
   endtask

   // Fetch with immediate ack on the first edge after the request rises
   task automatic fetch(input logic [31:0] word);
      ir_load = 1'b1;
      step();
      ir_load = 1'b0; imem_ack = 1'b1; imem_data = word;
      step();
      imem_ack = 1'b0; imem_data = 32'h0;
   endtask

   initial begin
      idle_inputs();
      rst_f = 1'b0;
      repeat (2) step();
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_ir", ir, 32'h0);
      chk("rst_req", 32'(imem_req), 32'h0);
      chk("rst_addr", 32'(imem_addr), 32'h0);
      chk("rst_stall", 32'(fetch_stall), 32'h0);
      chk("rst_fault", 32'(fetch_fault), 32'h0);
      rst_f = 1'b1;

      // Sequential fetch at pc=4 with concurrent increment, ack two cycles later
      for (int i = 0; i < 4; i++) pc_op(1'b0, 1'b0);
      chk("pc_4", 32'(pc), 32'h4);
      ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
      step();
      idle_inputs();
      chk("seq_addr", 32'(imem_addr), 32'h4);
      chk("seq_pc", 32'(pc), 32'h5);
      chk("seq_req", 32'(imem_req), 32'h1);
      chk("seq_stall1", 32'(fetch_stall), 32'h1);
      step();
      chk("seq_stall2", 32'(fetch_stall), 32'h1);
      chk("seq_ir_hold", ir, 32'h0);
      imem_ack = 1'b1; imem_data = 32'h8800_0005;
      step();
      idle_inputs();
      chk("seq_stall_done", 32'(fetch_stall), 32'h0);
      chk("seq_req_done", 32'(imem_req), 32'h0);
      chk("seq_ir", ir, 32'h8800_0005);
      chk("seq_opcode", 32'(opcode), 32'h8);
      chk("seq_mm", 32'(mm), 32'h8);
      chk("seq_imm", 32'(imm), 32'h5);

      // Stray ack while idle
      imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
      step();
      idle_inputs();
      chk("stray_ir", ir, 32'h8800_0005);
      chk("stray_req", 32'(imem_req), 32'h0);

      // Branches with imm=0x0010
      fetch(32'h0000_0010);
      chk("br_ir", ir, 32'h0000_0010);
      pc_op(1'b1, 1'b0);
      chk("br_abs", 32'(pc), 32'h0010);
      pc_op(1'b1, 1'b1);
      chk("br_rel_20", 32'(pc), 32'h0020);
      pc_op(1'b1, 1'b1);
      chk("br_rel_30", 32'(pc), 32'h0030);

      // Negative offset and wrap
      fetch(32'h0000_FFFE);
      pc_rst = 1'b1;
      step();
      pc_rst = 1'b0;
      chk("pc_clear", 32'(pc), 32'h0);
      pc_op(1'b0, 1'b0);
      pc_op(1'b1, 1'b1);
      chk("br_rel_neg", 32'(pc), 32'hFFFF);
      pc_op(1'b0, 1'b0);
      chk("pc_wrap", 32'(pc), 32'h0000);

      // Priority: pc_rst overrides a pending branch
      pc_op(1'b0, 1'b0);
      pc_op(1'b0, 1'b0);
      pc_op(1'b0, 1'b0);
      pc_rst = 1'b1; pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
      step();
      idle_inputs();
      chk("prio_pc_rst", 32'(pc), 32'h0);

      // ir_load and pc_rst during BUSY leave the transaction alone
      pc_op(1'b0, 1'b0);
      pc_op(1'b0, 1'b0);
      pc_op(1'b0, 1'b0);
      ir_load = 1'b1;
      step();
      chk("busy_addr", 32'(imem_addr), 32'h3);
      pc_write = 1'b1; pc_sel = 1'b0;
      step();
      idle_inputs();
      chk("busy_reload_addr", 32'(imem_addr), 32'h3);
      chk("busy_pc", 32'(pc), 32'h4);
      chk("busy_req", 32'(imem_req), 32'h1);
      pc_rst = 1'b1;
      step();
      pc_rst = 1'b0;
      chk("busy_pcrst_pc", 32'(pc), 32'h0);
      chk("busy_pcrst_req", 32'(imem_req), 32'h1);
      imem_ack = 1'b1; imem_data = 32'h1234_0042;
      step();
      idle_inputs();
      chk("busy_ir", ir, 32'h1234_0042);
      chk("busy_req_done", 32'(imem_req), 32'h0);

      // Timeout: no ack for 15 edges after the request rises
      ir_load = 1'b1;
      step();
      ir_load = 1'b0;
      for (int i = 0; i < 14; i++) step();
      chk("to_req_14", 32'(imem_req), 32'h1);
      chk("to_stall_14", 32'(fetch_stall), 32'h1);
      chk("to_fault_14", 32'(fetch_fault), 32'h0);
      step();
      chk("to_req", 32'(imem_req), 32'h0);
      chk("to_fault", 32'(fetch_fault), 32'h1);
      chk("to_opcode", 32'(opcode), 32'hF);
      chk("to_ir", ir, 32'hF000_0000);
      chk("to_stall", 32'(fetch_stall), 32'h0);
      ir_load = 1'b1;
      step();
      ir_load = 1'b0; imem_ack = 1'b1; imem_data = 32'h1111_1111;
      step();
      idle_inputs();
      chk("fault_req", 32'(imem_req), 32'h0);
      chk("fault_ir", ir, 32'hF000_0000);
      chk("fault_sticky", 32'(fetch_fault), 32'h1);

      // Asynchronous reset in the middle of a transaction
      rst_f = 1'b0;
      #2;
      rst_f = 1'b1;
      pc_op(1'b0, 1'b0);
      ir_load = 1'b1;
      step();
      ir_load = 1'b0;
      chk("arst_pre_req", 32'(imem_req), 32'h1);
      #2;
      rst_f = 1'b0;
      #1;
      chk("arst_req", 32'(imem_req), 32'h0);
      chk("arst_pc", 32'(pc), 32'h0);
      chk("arst_ir", ir, 32'h0);
      chk("arst_stall", 32'(fetch_stall), 32'h0);
      chk("arst_fault", 32'(fetch_fault), 32'h0);
      step();
      rst_f = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
